// File: rtl/cpc_loader_pkg.sv
// Shared types and constants for the CPC ROM loader: FSM states, special pages,
// the system-pack page table and the ASCII hex digit decoder.
package cpc_loader_pkg;

    typedef enum logic [1:0] {IDLE, ARM, LOAD, DRAIN} state_t;

    localparam logic [8:0] PAGE_BAD = 9'h1EE;
    localparam logic [8:0] PAGE_MF2 = 9'h1FF;

    // Index is block % 4 of the system ROM pack.
    localparam logic [3:0][8:0] SYS_PAGE = {9'h1FF, 9'h107, 9'h100, 9'h000};

    // Returns {valid, nibble}; only 0-9 and upper-case A-F are digits.
    function automatic logic [4:0] hex_nib(input logic [7:0] c);
        logic [7:0] v;
        v = 8'h00;
        if (c >= 8'h30 && c <= 8'h39) begin
            v = c - 8'h30;
            return {1'b1, v[3:0]};
        end
        if (c >= 8'h41 && c <= 8'h46) begin
            v = c - 8'h37;
            return {1'b1, v[3:0]};
        end
        return 5'h00;
    endfunction

endpackage

// File: rtl/cpc_ext_decode.sv
// Maps a two-character file extension to a 9-bit SDRAM ROM page plus the
// combo flag used by the "Z0" (ROM + Multiface) image.
module cpc_ext_decode
    import cpc_loader_pkg::*;
(
    input  logic [15:0] ext,
    output logic [8:0]  page,
    output logic        combo
);

    logic [4:0] hi;
    logic [4:0] lo;

    always_comb begin
        hi    = hex_nib(ext[15:8]);
        lo    = hex_nib(ext[7:0]);
        page  = PAGE_BAD;
        combo = 1'b0;
        if (ext == 16'h5A5A) begin
            page = 9'h000;
        end else if (ext == 16'h5A30) begin
            page  = 9'h000;
            combo = 1'b1;
        end else begin
            // Each valid digit overrides its nibble of the default; a fully
            // valid pair lands in the low (expansion) half of ROM space.
            if (hi[4]) page[7:4] = hi[3:0];
            if (lo[4]) page[3:0] = lo[3:0];
            page[8] = ~(hi[4] & lo[4]);
        end
    end

endmodule

// File: rtl/cpc_rom_loader.sv
// Sequences ioctl downloads into the SDRAM write port via a one-byte holding
// register and keeps the ROM-presence map. Optional LOADER_CHECKSUM_EN adds a byte sum.
module cpc_rom_loader
    import cpc_loader_pkg::*;
#(
    parameter int ADDR_W   = 23,
    parameter int MAP_W    = 8,
    parameter int SYS_BLKS = 8
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_index,
    input  logic [31:0]       ioctl_file_ext,
    input  logic              model,
    input  logic              mem_slot,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_bank,
    output logic [7:0]        mem_din,
    output logic              busy,
    output logic              overrun,
    input  logic [MAP_W-1:0]  map_addr,
    output logic              map_hit
`ifdef LOADER_CHECKSUM_EN
   ,output logic [15:0]       checksum
`endif
);

    state_t            state, state_nxt;
    logic              dl_q, wr_q, start_pend;
    logic              dl_rise, wr_fall;
    logic [8:0]        page, dec_page;
    logic              combo, dec_combo;
    logic              hold_v;
    logic [10:0]       blk;
    logic [8:0]        sys_pg;
    logic [ADDR_W-1:0] cap_addr;
    logic [1:0]        cap_bank;
    logic              cap_ok, capture, commit;
    logic [2**MAP_W-1:0] rom_map = '0;

    cpc_ext_decode u_dec (
        .ext   (ioctl_file_ext[15:0]),
        .page  (dec_page),
        .combo (dec_combo)
    );

    assign dl_rise = ioctl_download & ~dl_q;
    assign wr_fall = wr_q & ~ioctl_wr;

    always_comb begin
        blk    = ioctl_addr[24:14];
        sys_pg = SYS_PAGE[blk[1:0]];
        if (ioctl_index == 8'd0) begin
            cap_addr = ADDR_W'({sys_pg, ioctl_addr[13:0]});
            cap_bank = blk[3:2];
            cap_ok   = (blk < 11'(SYS_BLKS));
        end else begin
            cap_addr = ADDR_W'({page[8], page[7:0] + ioctl_addr[21:14], ioctl_addr[13:0]});
            cap_bank = {1'b0, model};
            cap_ok   = 1'b1;
        end
    end

    assign capture = (state == LOAD) & wr_fall & cap_ok;
    assign mem_we  = hold_v & mem_slot & ~reset;
    assign commit  = mem_we;

    // FSM: state register
    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (dl_rise | start_pend) state_nxt = ARM;
            ARM:   state_nxt = LOAD;
            LOAD:  if (!ioctl_download) state_nxt = DRAIN;
            DRAIN: if (!hold_v) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state != IDLE);
    end

    // Edge trackers follow the inputs through reset so a download already in
    // progress is not mistaken for a new one when reset releases.
    always_ff @(posedge clk_sys) begin
        dl_q <= ioctl_download;
        wr_q <= ioctl_wr;
        if (reset || state == ARM)         start_pend <= 1'b0;
        else if (dl_rise && state != IDLE) start_pend <= 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            page  <= PAGE_BAD;
            combo <= 1'b0;
        end else if (state == ARM) begin
            page  <= dec_page;
            combo <= dec_combo;
        end else if (commit && combo && mem_addr[13:0] == 14'h3FFF) begin
            page  <= PAGE_MF2;
            combo <= 1'b0;
        end
    end

    // A capture coinciding with a commit replaces the byte just written out.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hold_v   <= 1'b0;
            mem_addr <= '0;
            mem_bank <= 2'd0;
            mem_din  <= 8'd0;
            overrun  <= 1'b0;
        end else begin
            if (capture) begin
                hold_v   <= 1'b1;
                mem_addr <= cap_addr;
                mem_bank <= cap_bank;
                mem_din  <= ioctl_dout;
            end else if (commit) begin
                hold_v <= 1'b0;
            end
            if (state == ARM)           overrun <= 1'b0;
            else if (capture && hold_v) overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (commit && mem_addr[ADDR_W-1])
            rom_map[mem_addr[14 +: MAP_W]] <= 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) map_hit <= 1'b0;
        else       map_hit <= rom_map[map_addr];
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk_sys) begin
        if (reset || state == ARM) checksum <= 16'd0;
        else if (commit)           checksum <= checksum + {8'd0, mem_din};
    end
`endif

endmodule
